// File: rtl/revo_decoder_bunch_counter_pkg.sv
// Shared types and defaults for the revo decoder: FSM states, edge classes, interval classifier.
// The optional fake-revo recovery is enabled with the REVO_DECODER_FAKE_REVO_EN macro.
package revo_decoder_bunch_counter_pkg;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_ACQUIRE  = 2'd1,
      ST_LOCKED   = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      EC_NONE    = 3'd0,
      EC_NORMAL  = 3'd1,
      EC_GAP     = 3'd2,
      EC_GLITCH  = 3'd3,
      EC_TIMEOUT = 3'd4
   } edge_class_t;

   localparam int DEFAULT_OVERSAMPLE  = 4;
   localparam int DEFAULT_REVO_PERIOD = 1280;
   localparam int DEFAULT_LOCK_COUNT  = 4;
   localparam int DEFAULT_BUNCH_WIDTH = 11;
   localparam int DEFAULT_ERR_WIDTH   = 16;

   // A normal period is one encoded period +/-1 sample; a gap is two periods +/-1 sample.
   function automatic edge_class_t classify_interval(input int len, input int oversample);
      if (len >= oversample - 1 && len <= oversample + 1)
         return EC_NORMAL;
      if (len >= 2 * oversample - 1 && len <= 2 * oversample + 1)
         return EC_GAP;
      return EC_GLITCH;
   endfunction

endpackage

// File: rtl/revo_decoder_bunch_counter_edge_interval_classifier.sv
// Synchronises the encoded line, detects rising edges and classifies the interval between them.
// Emits a one-cycle class code in the cycle the edge (or timeout) is seen.
module revo_decoder_bunch_counter_edge_interval_classifier
   import revo_decoder_bunch_counter_pkg::*;
#(
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        encoded_in,
   output edge_class_t edge_class
);

   localparam int TIMEOUT = 4 * OVERSAMPLE;
   localparam int CW      = $clog2(TIMEOUT + 1);

   logic          sync1;
   logic          sync2;
   logic          sync2_d;
   logic          armed;
   logic [CW-1:0] interval;
   logic          edge_seen;
   logic          timed_out;

   assign edge_seen = sync2 & ~sync2_d;
   assign timed_out = armed && (interval == CW'(TIMEOUT));

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sync2_d  <= 1'b0;
         armed    <= 1'b0;
         interval <= '0;
      end else begin
         sync1   <= encoded_in;
         sync2   <= sync1;
         sync2_d <= sync2;
         // An edge restarts the count at 1 so the count equals L when the next edge arrives.
         if (edge_seen) begin
            armed    <= 1'b1;
            interval <= CW'(1);
         end else if (timed_out) begin
            armed    <= 1'b0;
            interval <= '0;
         end else if (armed) begin
            interval <= interval + CW'(1);
         end
      end
   end

   // NOTE: combinational outputs get a default first so no latch is inferred.
   always_comb begin
      edge_class = EC_NONE;
      if (edge_seen) begin
         if (armed)
            edge_class = classify_interval(int'(interval), OVERSAMPLE);
      end else if (timed_out) begin
         edge_class = EC_TIMEOUT;
      end
   end

endmodule

// File: rtl/revo_decoder_bunch_counter.sv
// Revo decoder: recovers revo pulse, bunch index, lock and framing-error count from the encoded line.
// Define REVO_DECODER_FAKE_REVO_EN to substitute a fake revo for a missing gap while locked.
module revo_decoder_bunch_counter
   import revo_decoder_bunch_counter_pkg::*;
#(
   parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
   parameter int REVO_PERIOD = DEFAULT_REVO_PERIOD,
   parameter int LOCK_COUNT  = DEFAULT_LOCK_COUNT,
   parameter int BUNCH_WIDTH = DEFAULT_BUNCH_WIDTH,
   parameter int ERR_WIDTH   = DEFAULT_ERR_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   encoded_in,
   output logic                   revo,
   output logic                   bunch_strobe,
   output logic [BUNCH_WIDTH-1:0] bunch_index,
   output logic                   locked,
   output logic [ERR_WIDTH-1:0]   error_count,
   output logic                   fake_revo
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam logic [BUNCH_WIDTH-1:0] EXPECT_IDX = BUNCH_WIDTH'(REVO_PERIOD - 2);
   localparam logic [BUNCH_WIDTH-1:0] LAST_IDX   = BUNCH_WIDTH'(REVO_PERIOD - 1);

   edge_class_t            edge_class;
   state_t                 state;
   state_t                 state_nxt;
   logic [GW-1:0]          good_count;
   logic [GW-1:0]          good_nxt;
   logic [BUNCH_WIDTH-1:0] index_nxt;
   logic                   revo_nxt;
   logic                   strobe_nxt;
   logic                   fake_revo_nxt;
   logic                   err_inc;
   logic                   at_expect;
`ifdef REVO_DECODER_FAKE_REVO_EN
   logic [GW-1:0]          fake_count;
   logic [GW-1:0]          fake_nxt;
`endif

   revo_decoder_bunch_counter_edge_interval_classifier #(
      .OVERSAMPLE (OVERSAMPLE)
   ) u_edge_interval_classifier (
      .clock      (clock),
      .reset      (reset),
      .encoded_in (encoded_in),
      .edge_class (edge_class)
   );

   assign at_expect = (bunch_index == EXPECT_IDX);
   assign locked    = (state == ST_LOCKED);

   always_comb begin
      state_nxt     = state;
      good_nxt      = good_count;
      index_nxt     = bunch_index;
      revo_nxt      = 1'b0;
      strobe_nxt    = 1'b0;
      fake_revo_nxt = 1'b0;
      err_inc       = 1'b0;
`ifdef REVO_DECODER_FAKE_REVO_EN
      fake_nxt      = fake_count;
`endif

      case (edge_class)
         EC_NORMAL: begin
            strobe_nxt = 1'b1;
            if (bunch_index != LAST_IDX)
               index_nxt = bunch_index + BUNCH_WIDTH'(1);
         end
         EC_GAP: begin
            strobe_nxt = 1'b1;
            index_nxt  = '0;
         end
         default: ;
      endcase

      case (state)
         ST_UNLOCKED: begin
            if (edge_class == EC_GAP) begin
               state_nxt = ST_ACQUIRE;
               good_nxt  = GW'(1);
            end
         end
         ST_ACQUIRE: begin
            if (edge_class == EC_GLITCH || edge_class == EC_TIMEOUT ||
                (edge_class == EC_NORMAL && at_expect)) begin
               state_nxt = ST_UNLOCKED;
            end else if (edge_class == EC_GAP) begin
               if (!at_expect) begin
                  good_nxt = GW'(1);
               end else if (good_count == GW'(LOCK_COUNT)) begin
                  // Entry gap plus LOCK_COUNT confirmed gaps: lock on this edge.
                  state_nxt = ST_LOCKED;
                  revo_nxt  = 1'b1;
`ifdef REVO_DECODER_FAKE_REVO_EN
                  fake_nxt  = '0;
`endif
               end else begin
                  good_nxt = good_count + GW'(1);
               end
            end
         end
         ST_LOCKED: begin
            if (edge_class == EC_GAP) begin
               if (at_expect) begin
                  revo_nxt = 1'b1;
`ifdef REVO_DECODER_FAKE_REVO_EN
                  fake_nxt = '0;
`endif
               end else begin
                  err_inc   = 1'b1;
                  state_nxt = ST_ACQUIRE;
                  good_nxt  = GW'(1);
               end
            end else if (edge_class == EC_GLITCH || edge_class == EC_TIMEOUT) begin
               err_inc   = 1'b1;
               state_nxt = ST_UNLOCKED;
            end else if (edge_class == EC_NORMAL && at_expect) begin
               err_inc = 1'b1;
`ifdef REVO_DECODER_FAKE_REVO_EN
               if (fake_count == GW'(LOCK_COUNT - 1)) begin
                  state_nxt = ST_UNLOCKED;
               end else begin
                  fake_nxt      = fake_count + GW'(1);
                  revo_nxt      = 1'b1;
                  fake_revo_nxt = 1'b1;
                  index_nxt     = '0;
               end
`else
               state_nxt = ST_UNLOCKED;
`endif
            end
         end
         default: state_nxt = ST_UNLOCKED;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_UNLOCKED;
         good_count   <= '0;
         bunch_index  <= '0;
         error_count  <= '0;
         revo         <= 1'b0;
         bunch_strobe <= 1'b0;
         fake_revo    <= 1'b0;
      end else begin
         state        <= state_nxt;
         good_count   <= good_nxt;
         bunch_index  <= index_nxt;
         revo         <= revo_nxt;
         bunch_strobe <= strobe_nxt;
         fake_revo    <= fake_revo_nxt;
         if (err_inc && error_count != '1)
            error_count <= error_count + ERR_WIDTH'(1);
      end
   end

`ifdef REVO_DECODER_FAKE_REVO_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         fake_count <= '0;
      else
         fake_count <= fake_nxt;
   end
`endif

endmodule
